misr_compactor: RTL and testbench
=================================

MISR_COMPACTOR -- requirements
Module: misr_compactor

Interface
REQ-001 Parameter WIDTH, default 16, signature register width (4..64).
REQ-002 Parameter NIN, default 1, parallel response bits compacted per cycle (1..WIDTH).
REQ-003 Parameter POLY, default 16'h002D (x^16+x^5+x^3+x^2+1), feedback tap mask, WIDTH bits; bit i set = feedback XORed into stage i.
REQ-004 Parameter SEED, default all-zero, signature value loaded at reset and at session start.
REQ-005 Parameter CNT_W, default 16, width of the session length counter.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 start  input  1  one-cycle request to begin a compaction session.
REQ-009 abort  input  1  terminates the current session.
REQ-010 len  input  CNT_W  number of valid samples in the session; sampled on accepted start.
REQ-011 golden  input  WIDTH  expected signature; sampled on accepted start.
REQ-012 din_valid  input  1  din carries a response sample this cycle.
REQ-013 din  input  NIN  response bits from scan-out taps of the circuit under test.
REQ-014 signature  output  WIDTH  current signature register.
REQ-015 busy  output  1  high in COMPACT.
REQ-016 done  output  1  high in DONE.
REQ-017 pass  output  1  done AND (signature == latched golden), combinational from registers.

Function
REQ-018 FSM states: IDLE, COMPACT, DONE.
REQ-019 Step rule (Galois): fb = sig[WIDTH-1]; next[i] = (i>0 ? sig[i-1] : 0) ^ (POLY[i] & fb) ^ (i<NIN ? din[i] : 0).
REQ-020 start accepted in IDLE or DONE: signature<=SEED, counter<=len, golden latched; next state COMPACT, or DONE if len==0.
REQ-021 start in COMPACT is ignored.
REQ-022 In COMPACT, din_valid=1: signature steps once, counter decrements; if counter was 1, next state DONE.
REQ-023 In COMPACT, din_valid=0: signature and counter hold (stall); no cycle limit.
REQ-024 din_valid outside COMPACT is ignored; signature holds.
REQ-025 done asserts the cycle after the edge accepting the last sample; signature final at that cycle.
REQ-026 DONE persists, signature frozen, until start, abort or rst.
REQ-027 abort in any state: next state IDLE, signature holds; abort takes priority over start and din_valid in the same cycle.
REQ-028 Counter never wraps; len up to 2^CNT_W-1 supported.

Reset
REQ-029 On rst: state IDLE, signature=SEED, counter=0, latched golden=0; busy=0, done=0, pass=0 the following cycle.
REQ-030 rst overrides start, abort and din_valid; rst mid-session discards it.

Structure
REQ-031 Package misr_pkg holds the state enum and default constants (DEFAULT_POLY16=16'h002D, DEFAULT_WIDTH=16).
REQ-032 Sub-module misr_core: WIDTH/NIN/POLY/SEED register with load, enable and the REQ-019 step; misr_compactor adds FSM, counter, golden latch and compare.

Verification (WIDTH=16, NIN=1, POLY=16'h002D, SEED=0)
REQ-033 start, len=1, din=1 valid one cycle -> next cycle done=1, signature=16'h0001.
REQ-034 start, len=16, din=1 then fifteen din=0 -> signature=16'h8000; len=17 with one extra din=0 -> signature=16'h002D (feedback taps).
REQ-035 len=17 run as REQ-034 with din_valid low for 5 cycles mid-stream -> identical 16'h002D, done delayed 5 cycles, busy high throughout.
REQ-036 golden=16'h002D with REQ-034 -> pass=1; golden=16'h002C -> done=1, pass=0.
REQ-037 len=0 start -> DONE next cycle, signature=16'h0000; start during COMPACT -> ignored, count unaffected.
REQ-038 rst or abort asserted mid-session after 3 samples -> IDLE next cycle, busy=0, done=0; rst gives signature 16'h0000, abort holds signature.

Source files
------------

// File: rtl/misr_pkg.sv
// Shared types and default constants for the MISR signature compactor.
package misr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPACT,
        ST_DONE
    } state_t;

    localparam int          DEFAULT_WIDTH  = 16;
    localparam logic [15:0] DEFAULT_POLY16 = 16'h002D;

endpackage

// File: rtl/misr_core.sv
// Galois-form multiple-input signature register with synchronous load and step enable.
module misr_core
    import misr_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_WIDTH,
    parameter int               NIN   = 1,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY16),
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [NIN-1:0]   din,
    output logic [WIDTH-1:0] sig
);

    // Shift toward the MSB, fold the MSB back through the tap mask, then mix the inputs into the low stages.
    function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s,
                                                   input logic [NIN-1:0]   d);
        logic [WIDTH-1:0] n;
        n = {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? POLY : '0);
        n[NIN-1:0] = n[NIN-1:0] ^ d;
        return n;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (en) begin
            sig <= misr_step(sig, din);
        end
    end

endmodule

// File: rtl/misr_compactor.sv
// Session controller around misr_core: sample counting, golden latch and pass/fail compare.
module misr_compactor
    import misr_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_WIDTH,
    parameter int               NIN   = 1,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY16),
    parameter logic [WIDTH-1:0] SEED  = '0,
    parameter int               CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] len,
    input  logic [WIDTH-1:0] golden,
    input  logic             din_valid,
    input  logic [NIN-1:0]   din,
    output logic [WIDTH-1:0] signature,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] golden_q;
    logic             start_ok;
    logic             sample;

    // abort outranks both a new session and a pending sample
    assign start_ok = start && !abort && (state != ST_COMPACT);
    assign sample   = din_valid && !abort && (state == ST_COMPACT);

    misr_core #(
        .WIDTH (WIDTH),
        .NIN   (NIN),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .load (start_ok),
        .en   (sample),
        .din  (din),
        .sig  (signature)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_nxt = (len == '0) ? ST_DONE : ST_COMPACT;
                    end
                end
                ST_COMPACT: begin
                    if (din_valid && (count == CNT_W'(1))) begin
                        state_nxt = ST_DONE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == ST_COMPACT);
        done = (state == ST_DONE);
    end

    // COMPACT is only entered with a non-zero count, so the decrement stops at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            golden_q <= '0;
        end else if (start_ok) begin
            count    <= len;
            golden_q <= golden;
        end else if (sample) begin
            count    <= count - CNT_W'(1);
        end
    end

    assign pass = done && (signature == golden_q);

endmodule

// File: tb/tb_misr_compactor.sv
// Self-checking bench for misr_compactor: directed table, corner-case sequences and random sessions.
module tb_misr_compactor;

    localparam int W  = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [CW-1:0] len;
    logic [W-1:0]  golden;
    logic          din_valid;
    logic [0:0]    din;
    logic [W-1:0]  signature;
    logic          busy;
    logic          done;
    logic          pass;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    misr_compactor #(
        .WIDTH (W),
        .NIN   (1),
        .POLY  (16'h002D),
        .SEED  (16'h0000),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .len       (len),
        .golden    (golden),
        .din_valid (din_valid),
        .din       (din),
        .signature (signature),
        .busy      (busy),
        .done      (done),
        .pass      (pass)
    );

    typedef struct {
        int          n;
        logic [63:0] bits;
        logic [15:0] gold;
        logic [15:0] exp_sig;
        logic        exp_pass;
    } vec_t;

    vec_t tbl[7];

    // Reference: signature = sum of d_k * x^(n-1-k) reduced modulo x^16+x^5+x^3+x^2+1.
    function automatic logic [15:0] model_sig(input logic [63:0] bits, input int n);
        longint unsigned s;
        s = 0;
        for (int k = 0; k < n; k++) begin
            s = s * 2;
            if ((s & 64'h10000) != 0) s = s ^ 64'h1002D;
            if (bits[k]) s = s ^ 64'h1;
        end
        return s[15:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int l, input logic [15:0] g);
        start  = 1'b1;
        len    = l[CW-1:0];
        golden = g;
        tick();
        start  = 1'b0;
    endtask

    task automatic feed(input logic b);
        din_valid = 1'b1;
        din       = b;
        tick();
        din_valid = 1'b0;
        din       = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; len = '0; golden = '0;
        din_valid = 1'b0; din = 1'b0;

        tbl[0] = '{n: 1,  bits: 64'h1, gold: 16'h0001, exp_sig: 16'h0001, exp_pass: 1'b1};
        tbl[1] = '{n: 16, bits: 64'h1, gold: 16'h0000, exp_sig: 16'h8000, exp_pass: 1'b0};
        tbl[2] = '{n: 17, bits: 64'h1, gold: 16'h002D, exp_sig: 16'h002D, exp_pass: 1'b1};
        tbl[3] = '{n: 17, bits: 64'h1, gold: 16'h002C, exp_sig: 16'h002D, exp_pass: 1'b0};
        tbl[4] = '{n: 0,  bits: 64'h0, gold: 16'h0000, exp_sig: 16'h0000, exp_pass: 1'b1};
        tbl[5] = '{n: 2,  bits: 64'h3, gold: 16'h0003, exp_sig: 16'h0003, exp_pass: 1'b1};
        tbl[6] = '{n: 3,  bits: 64'h5, gold: 16'h0004, exp_sig: 16'h0005, exp_pass: 1'b0};

        tick(); tick();
        rst = 1'b0;
        chk("reset_sig",  signature, 16'h0000);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_pass", pass, 1'b0);

        for (int i = 0; i < 7; i++) begin
            do_start(tbl[i].n, tbl[i].gold);
            if (tbl[i].n > 0) chk($sformatf("tbl%0d_busy", i), busy, 1'b1);
            for (int k = 0; k < tbl[i].n; k++) feed(tbl[i].bits[k]);
            chk($sformatf("tbl%0d_done", i), done, 1'b1);
            chk($sformatf("tbl%0d_nbusy", i), busy, 1'b0);
            chk($sformatf("tbl%0d_sig", i), signature, tbl[i].exp_sig);
            chk($sformatf("tbl%0d_pass", i), pass, tbl[i].exp_pass);
        end

        // 17 samples with a 5-cycle stall after the eighth
        do_start(17, 16'h002D);
        feed(1'b1);
        for (int k = 0; k < 7; k++) feed(1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_busy", busy, 1'b1);
            chk("stall_done", done, 1'b0);
        end
        for (int k = 0; k < 8; k++) feed(1'b0);
        chk("stall_busy_last", busy, 1'b1);
        feed(1'b0);
        chk("stall_done_end", done, 1'b1);
        chk("stall_sig", signature, 16'h002D);
        chk("stall_pass", pass, 1'b1);

        // DONE holds with frozen signature despite further samples
        for (int k = 0; k < 3; k++) feed(1'b1);
        chk("done_hold", done, 1'b1);
        chk("done_frozen_sig", signature, 16'h002D);

        // start during COMPACT is ignored
        do_start(3, 16'h0005);
        feed(1'b1);
        start = 1'b1; len = 16'd1; golden = 16'h0001;
        feed(1'b0);
        start = 1'b0;
        chk("ign_start_busy", busy, 1'b1);
        chk("ign_start_done", done, 1'b0);
        feed(1'b1);
        chk("ign_start_done2", done, 1'b1);
        chk("ign_start_sig", signature, 16'h0005);
        chk("ign_start_pass", pass, 1'b1);

        // reset mid-session
        do_start(10, 16'h0000);
        feed(1'b1); feed(1'b0); feed(1'b1);
        rst = 1'b1; start = 1'b1; din_valid = 1'b1; din = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; din_valid = 1'b0; din = 1'b0;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        chk("rst_mid_sig", signature, 16'h0000);
        chk("rst_mid_pass", pass, 1'b0);

        // abort mid-session beats start and din_valid in the same cycle
        do_start(10, 16'h0000);
        feed(1'b1); feed(1'b0); feed(1'b1);
        abort = 1'b1; start = 1'b1; len = 16'd0; din_valid = 1'b1; din = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0; din_valid = 1'b0; din = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_sig", signature, 16'h0005);
        feed(1'b1);
        chk("idle_valid_sig", signature, 16'h0005);
        chk("idle_valid_busy", busy, 1'b0);

        // random sessions with random stalls
        for (int s = 0; s < 30; s++) begin
            int          n;
            logic [63:0] bits;
            logic [15:0] exp_sig;
            logic [15:0] gold;
            n       = $urandom_range(0, 40);
            bits    = {$urandom, $urandom};
            exp_sig = model_sig(bits, n);
            gold    = ($urandom_range(0, 1) == 1) ? exp_sig : exp_sig ^ (16'h1 << $urandom_range(0, 15));
            do_start(n, gold);
            for (int k = 0; k < n; k++) begin
                int st;
                st = $urandom_range(0, 2);
                for (int j = 0; j < st; j++) begin
                    tick();
                    chk("rnd_stall_busy", busy, 1'b1);
                end
                feed(bits[k]);
            end
            chk($sformatf("rnd%0d_done", s), done, 1'b1);
            chk($sformatf("rnd%0d_sig", s), signature, exp_sig);
            chk($sformatf("rnd%0d_pass", s), pass, gold == exp_sig);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
